// File: rtl/dual_timer_scheduler.sv
// dual_timer_scheduler
//   Two serial requesters share one countdown engine. Each channel hunts for
//   the start pattern 1101 on its data bit. It then shifts in a 4-bit delay
//   (MSB first) and requests the engine. A round-robin arbiter hands the
//   engine out. The engine counts (delay+1)*TICKS cycles, and the channel then
//   holds done until it is acknowledged.
//
// Ports
//   clk        : sole clock, rising edge
//   reset      : synchronous, active-high; clears all state
//   data[1:0]  : serial input bit per channel
//   ack[1:0]   : per-channel acknowledge, honoured only in DONE
//   pending    : channel waiting for the engine
//   counting   : channel owning the running engine (one-hot or zero)
//   done       : channel finished, waiting for ack
//   active_ch  : channel owning the engine, 0 when idle
//   count      : remaining delay units of the running job, 0 when idle
//
// Per-channel states
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_IDLE  | hunting for 1101 in the serial stream (overlap allowed)
//   S_SHIFT | capturing the 4 delay bits, MSB first
//   S_PEND  | delay captured, waiting for an engine grant
//   S_RUN   | engine counting for this channel
//   S_DONE  | job finished, done asserted until ack

module dual_timer_scheduler #(
  parameter int TICKS = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] data,
  input  logic [1:0] ack,
  output logic [1:0] pending,
  output logic [1:0] counting,
  output logic [1:0] done,
  output logic       active_ch,
  output logic [3:0] count
);

  localparam int TW = $clog2(TICKS);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_PEND,
    S_RUN,
    S_DONE
  } ch_state_t;

  ch_state_t       state_q [2];
  ch_state_t       state_d [2];
  // Three previous bits; together with the current bit they form the
  // 4-bit search window.
  logic [2:0]      hist_q  [2];
  logic [1:0]      bit_cnt_q [2];
  logic [3:0]      delay_q [2];

  logic [TW-1:0]   tick_q;
  logic [3:0]      remaining_q;
  logic            rr_ptr_q;

  logic            run_any;
  logic            last_cycle;
  logic            engine_free;
  logic            pend0;
  logic            pend1;
  logic            grant_valid;
  logic            grant_ch;

  // Arbitration. The engine is treated as free during the final cycle of
  // the running job, so a waiting channel starts on the very next cycle and
  // the engine never sits idle while a request is pending.
  always_comb begin
    run_any     = (state_q[0] == S_RUN) || (state_q[1] == S_RUN);
    last_cycle  = run_any && (tick_q == TICK_LAST) && (remaining_q == 4'd0);
    engine_free = !run_any || last_cycle;
    pend0       = (state_q[0] == S_PEND);
    pend1       = (state_q[1] == S_PEND);
    grant_valid = engine_free && (pend0 || pend1);
    grant_ch    = (pend0 && pend1) ? rr_ptr_q : pend1;
  end

  // State register
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (reset) state_q[c] <= S_IDLE;
      else       state_q[c] <= state_d[c];
    end
  end

  // Next-state logic
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      state_d[c] = state_q[c];
      case (state_q[c])
        S_IDLE:  if ({hist_q[c], data[c]} == 4'b1101) state_d[c] = S_SHIFT;
        S_SHIFT: if (bit_cnt_q[c] == 2'd3) state_d[c] = S_PEND;
        S_PEND:  if (grant_valid && (grant_ch == c[0])) state_d[c] = S_RUN;
        S_RUN:   if (last_cycle) state_d[c] = S_DONE;
        S_DONE:  if (ack[c]) state_d[c] = S_IDLE;
        default: state_d[c] = S_IDLE;
      endcase
    end
  end

  // Outputs, decoded from registered state only
  always_comb begin
    pending   = 2'b00;
    counting  = 2'b00;
    done      = 2'b00;
    for (int c = 0; c < 2; c++) begin
      pending[c]  = (state_q[c] == S_PEND);
      counting[c] = (state_q[c] == S_RUN);
      done[c]     = (state_q[c] == S_DONE);
    end
    active_ch = (state_q[1] == S_RUN);
    count     = run_any ? remaining_q : 4'd0;
  end

  // Per-channel datapath: pattern history and delay shift register
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (reset) begin
        hist_q[c]    <= 3'd0;
        bit_cnt_q[c] <= 2'd0;
        delay_q[c]   <= 4'd0;
      end else begin
        case (state_q[c])
          S_IDLE: begin
            bit_cnt_q[c] <= 2'd0;
            if (state_d[c] == S_SHIFT) hist_q[c] <= 3'd0;
            else                       hist_q[c] <= {hist_q[c][1:0], data[c]};
          end
          S_SHIFT: begin
            delay_q[c]   <= {delay_q[c][2:0], data[c]};
            bit_cnt_q[c] <= bit_cnt_q[c] + 2'd1;
          end
          S_DONE: if (ack[c]) hist_q[c] <= 3'd0;
          default: ;
        endcase
      end
    end
  end

  // Shared engine. A grant takes priority over the final-cycle wrap so that
  // a back-to-back job loads its own delay.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q      <= '0;
      remaining_q <= 4'd0;
      rr_ptr_q    <= 1'b0;
    end else if (grant_valid) begin
      tick_q      <= '0;
      remaining_q <= delay_q[grant_ch];
      rr_ptr_q    <= ~grant_ch;
    end else if (run_any) begin
      if (tick_q == TICK_LAST) begin
        tick_q <= '0;
        if (remaining_q != 4'd0) remaining_q <= remaining_q - 4'd1;
      end else begin
        tick_q <= tick_q + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_dual_timer_scheduler.sv
// Directed bench for dual_timer_scheduler with TICKS=4. The driver pushes
// the expected post-edge outputs for every cycle it drives. The monitor pops
// and compares them on the following falling edge.

module tb_dual_timer_scheduler;

  logic       clk;
  logic       reset;
  logic [1:0] data;
  logic [1:0] ack;
  logic [1:0] pending;
  logic [1:0] counting;
  logic [1:0] done;
  logic       active_ch;
  logic [3:0] count;

  dual_timer_scheduler #(.TICKS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .data      (data),
    .ack       (ack),
    .pending   (pending),
    .counting  (counting),
    .done      (done),
    .active_ch (active_ch),
    .count     (count)
  );

  typedef struct {
    logic [1:0] pend;
    logic [1:0] cnt;
    logic [1:0] dn;
    logic       act;
    logic [3:0] cval;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   n_vec  = 0;
  int   n_miss = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e_mon = exp_q.pop_front();
        n_vec++;
        if ({pending, counting, done, active_ch, count} !==
            {e_mon.pend, e_mon.cnt, e_mon.dn, e_mon.act, e_mon.cval}) begin
          n_miss++;
          $display("FAIL %s @%0t: got pend=%b cnt=%b done=%b act=%b count=%0d, want pend=%b cnt=%b done=%b act=%b count=%0d",
                   e_mon.tag, $time, pending, counting, done, active_ch, count,
                   e_mon.pend, e_mon.cnt, e_mon.dn, e_mon.act, e_mon.cval);
        end
      end
    end
  end

  // Drive one cycle and queue the outputs expected after its rising edge.
  task automatic cyc(input logic [1:0] d, input logic [1:0] a, input logic r,
                     input logic [1:0] ep, input logic [1:0] ec,
                     input logic [1:0] ed, input logic eact,
                     input logic [3:0] ecnt, input string tag);
    exp_t e;
    data  = d;
    ack   = a;
    reset = r;
    e.pend = ep;
    e.cnt  = ec;
    e.dn   = ed;
    e.act  = eact;
    e.cval = ecnt;
    e.tag  = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // 4 pattern bits then 4 delay bits, MSB first, per channel. Outputs stay
  // 0 until the last delay bit, after which the channels in ep are pending.
  task automatic start_job(input logic [3:0] p0, input logic [3:0] p1,
                           input logic [3:0] d0, input logic [3:0] d1,
                           input logic [1:0] a, input logic [1:0] ep,
                           input string tag);
    for (int i = 3; i >= 0; i--)
      cyc({p1[i], p0[i]}, a, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 4'd0, tag);
    for (int i = 3; i >= 0; i--)
      cyc({d1[i], d0[i]}, a, 1'b0, (i == 0) ? ep : 2'b00, 2'b00, 2'b00,
          1'b0, 4'd0, tag);
  endtask

  initial begin
    data  = 2'b00;
    ack   = 2'b00;
    reset = 1'b1;

    // Reset with random data, then check that history was cleared.
    repeat (2) cyc(2'($urandom_range(0, 3)), 2'b00, 1'b1, 0, 0, 0, 0, 0, "rst");
    cyc(2'b01, 2'b00, 1'b0, 0, 0, 0, 0, 0, "rst_idle");
    cyc(2'b01, 2'b00, 1'b0, 0, 0, 0, 0, 0, "rst_idle");
    cyc(2'b00, 2'b00, 1'b0, 0, 0, 0, 0, 0, "rst_idle");
    repeat (2) cyc(2'($urandom_range(0, 3)), 2'b00, 1'b1, 0, 0, 0, 0, 0, "rst_hist");
    cyc(2'b01, 2'b00, 1'b0, 0, 0, 0, 0, 0, "rst_hist");
    repeat (7) cyc(2'b00, 2'b00, 1'b0, 0, 0, 0, 0, 0, "rst_hist");

    // Contention: both pending together, d0=1, d1=0, pointer at ch0.
    start_job(4'b1101, 4'b1101, 4'b0001, 4'b0000, 2'b00, 2'b11, "cont_start");
    for (int i = 0; i < 8; i++)
      cyc(2'b00, 2'b00, 1'b0, 2'b10, 2'b01, 2'b00, 1'b0, (i < 4) ? 4'd1 : 4'd0, "cont_ch0");
    for (int i = 0; i < 4; i++)
      cyc(2'b00, 2'b00, 1'b0, 2'b00, 2'b10, 2'b01, 1'b1, 4'd0, "cont_ch1");
    cyc(2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b11, 1'b0, 4'd0, "cont_done");
    cyc(2'b00, 2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 4'd0, "cont_ack");

    // Overlapping detect on 1,1,1,0,1, d=0; patterns in RUN/DONE ignored.
    cyc(2'b01, 2'b00, 1'b0, 0, 0, 0, 0, 0, "ovl_pre");
    start_job(4'b1101, 4'b0000, 4'b0000, 4'b0000, 2'b00, 2'b01, "ovl_start");
    cyc(2'b01, 2'b00, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 4'd0, "ovl_run");
    cyc(2'b01, 2'b00, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 4'd0, "ovl_run");
    cyc(2'b00, 2'b00, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 4'd0, "ovl_run");
    cyc(2'b01, 2'b00, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 4'd0, "ovl_run");
    cyc(2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 4'd0, "ovl_done");
    cyc(2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 4'd0, "ovl_done");
    cyc(2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 4'd0, "ovl_done");
    cyc(2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 4'd0, "ovl_done");
    cyc(2'b00, 2'b01, 1'b0, 0, 0, 0, 0, 0, "ovl_ack");
    repeat (6) cyc(2'b00, 2'b00, 1'b0, 0, 0, 0, 0, 0, "ovl_quiet");

    // Pointer now at ch1: simultaneous request, ch1 (d=2) wins, then reset
    // in the middle of its count=1 phase.
    start_job(4'b1101, 4'b1101, 4'b0000, 4'b0010, 2'b00, 2'b11, "rr_start");
    for (int i = 0; i < 4; i++)
      cyc(2'b00, 2'b00, 1'b0, 2'b01, 2'b10, 2'b00, 1'b1, 4'd2, "rr_ch1");
    for (int i = 0; i < 2; i++)
      cyc(2'b00, 2'b00, 1'b0, 2'b01, 2'b10, 2'b00, 1'b1, 4'd1, "rr_ch1");
    cyc(2'b00, 2'b00, 1'b1, 0, 0, 0, 0, 0, "rst_run");
    repeat (8) cyc(2'b00, 2'b00, 1'b0, 0, 0, 0, 0, 0, "post_rst");

    // Single job on ch0 with d=2 after the reset.
    start_job(4'b1101, 4'b0000, 4'b0010, 4'b0000, 2'b00, 2'b01, "single_start");
    for (int i = 0; i < 12; i++)
      cyc(2'b00, 2'b00, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 4'(2 - i / 4), "single_run");
    for (int i = 0; i < 3; i++)
      cyc(2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 4'd0, "single_done");
    cyc(2'b00, 2'b01, 1'b0, 0, 0, 0, 0, 0, "single_ack");
    cyc(2'b00, 2'b00, 1'b0, 0, 0, 0, 0, 0, "single_idle");

    // ack[0] held high for the whole job: done lasts exactly one cycle.
    start_job(4'b1101, 4'b0000, 4'b0001, 4'b0000, 2'b01, 2'b01, "ackm_start");
    for (int i = 0; i < 8; i++)
      cyc(2'b00, 2'b01, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, (i < 4) ? 4'd1 : 4'd0, "ackm_run");
    cyc(2'b00, 2'b01, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 4'd0, "ackm_done");
    repeat (2) cyc(2'b00, 2'b01, 1'b0, 0, 0, 0, 0, 0, "ackm_gone");

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d unchecked vectors, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
